tb_mem_sched: RTL and testbench
===============================

# tb_mem_sched

Survivor-memory scheduler for the Viterbi decoder, sitting between the ACS array, the shared single-port survivor RAM, and the TBU. It arbitrates the one RAM port between survivor writes and traceback reads, rotates four RAM banks, and sequences the TBU through its Init / traceback / decode phases via `Init`, `TB_EN` and `Hold`. A traceback job starts each time a bank fills, with write traffic always taking priority over reads.

## Interface
Parameters:
- `WD_FSM`, default 6: log2 of bank depth; each bank holds 2^WD_FSM survivor words.
- `N_BANK`, fixed at 4: banks addressed by 2 MSBs; not overridable.

Ports:
- `CLOCK`  in  1  single system clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `SurvValid`  in  1  ACS presents a survivor word this cycle; must be written this cycle.
- `RamWe`  out  1  RAM write strobe.
- `RamAddr`  out  WD_FSM+2  RAM address, {bank[1:0], step[WD_FSM-1:0]}.
- `Init`  out  1  one-cycle TBU init pulse at job start.
- `TB_EN`  out  1  TBU step enable; also RAM read strobe.
- `Hold`  out  1  TBU output-valid phase (decode phase).
- `Busy`  out  1  job active (state != IDLE).
- `Overrun`  out  1  sticky: a job was preempted by a new bank rotation.

## Operation
- Write side: counters `wbank` (2b) and `wstep` (WD_FSM b). On `SurvValid`: `RamWe`=1, `RamAddr`={wbank,wstep}, `wstep`++. When `wstep`=all-ones is written: `wstep`→0, `wbank`→wbank+1 mod 4 (rotation), `fill`=min(fill+1,2). The just-completed bank C is the old `wbank`.
- Job launch: on rotation with post-increment `fill`=2, latch C; FSM → INIT.
- FSM states: IDLE, INIT, TB, DEC.
  - IDLE: no reads.
  - INIT: `Init`=1 for exactly one cycle, no RAM access, unconditional; `rstep`←all-ones, `rbank`←C; → TB.
  - TB: read {rbank,rstep} in grant cycles; `Hold`=0. After step 0 is read: `rbank`←C−1 mod 4, `rstep`←all-ones; → DEC.
  - DEC: same read pattern with `Hold`=1. After step 0 is read → IDLE.
- Arbitration: grant = state∈{TB,DEC} && !SurvValid. `TB_EN`=grant; `rstep` decrements only on grant. With `SurvValid`=1, `RamAddr` is the write address, `TB_EN`=0, and read position is held.
- `RamAddr` when neither write nor grant: {rbank,rstep} (don't-care for RAM, but defined).
- Preemption: a rotation that occurs while state≠IDLE sets `Overrun`=1, abandons the job, and relaunches from INIT on the new C.
- A job's final read cannot coincide with a rotation, because reads happen only when `SurvValid`=0.
- Bank C+1 is being written while C and C−1 are read. C+2 is slack.

## Timing
- Reset values: `RamWe`=0, `TB_EN`=0, `Init`=0, `Hold`=0, `Busy`=0, `Overrun`=0, `RamAddr`=0. State=IDLE; wbank, wstep, fill, rbank, rstep = 0.
- `RamWe`, `TB_EN`, `RamAddr` are combinational from `SurvValid` and registered state, with zero latency. `Init`, `Hold` and `Busy` decode the registered state only.
- Rotation edge → `Init` high in the next cycle → first TB read possible the cycle after.
- Job length = 1 + 2·2^WD_FSM grant cycles. No overrun requires ≥ 2·2^WD_FSM+1 idle cycles per 2^WD_FSM writes, i.e. `SurvValid` duty ≤ ~1/3.
- `Reset` mid-operation: the next cycle shows reset values. `fill` restarts at 0, so the next job waits for two full banks.

## Configuration
- `TB_OVR_CNT_EN` defined: adds output `OvrCount` (8 bits, reset 0), incremented on each preemption and saturating at 255. `Overrun` is unchanged.
- Undefined: no `OvrCount` port; only the sticky `Overrun` flag.

## Test plan
- Reset, then `SurvValid`=0 for 50 cycles → every output 0, `Busy`=0, no `TB_EN`.
- `SurvValid` every 3rd cycle, 128 writes (WD_FSM=6) → `RamAddr` 0..127 on writes. Rotation at write 64 launches no job. After write 128: `Init` for one cycle, then 64 `TB_EN` on 127→64 with `Hold`=0, then 64 on 63→0 with `Hold`=1, then `Busy`=0 and `Overrun`=0.
- Collision: `SurvValid`=1 during TB at `rstep`=40 → that cycle `RamWe`=1, `TB_EN`=0, `RamAddr`=write address. Next idle cycle reads step 40 of the same bank again.
- `SurvValid` held at 1 for 192 cycles, then 0 → no `TB_EN` is ever granted. Rotation at write 192 sets `Overrun`=1 and relaunches INIT with C=bank 2. Reads then cover 191→128, then 127→64.
- Wrap: 256+ writes at 1/3 duty → write address wraps 255→0. The job at rotation 256 reads 255→192 then 191→128, with `Overrun`=0.
- `Reset` during DEC → next cycle all outputs 0. The subsequent 64 writes launch no job; the job launches only at write 128 after reset.

Source files
------------

// File: rtl/tb_mem_sched.sv
// ---------------------------------------------------------------------------
// tb_mem_sched -- survivor-memory scheduler for the Viterbi decoder.
//
// This module shares the single survivor RAM port between two users:
//   - ACS survivor writes, which always win the port.
//   - TBU traceback reads, which only use cycles with no write.
// The RAM is split into four banks. A traceback job starts each time a bank
// fills. The job reads the completed bank C from top to bottom (traceback
// phase), then reads bank C-1 from top to bottom (decode phase, Hold=1).
//
// Optional build macro: TB_OVR_CNT_EN
//   When defined, the module adds an 8-bit saturating preemption counter,
//   output as OvrCount.
//
// Parameters:
//   WD_FSM     log2 of the bank depth (2^WD_FSM words per bank)
//
// Ports:
//   CLOCK      in   system clock, rising edge
//   Reset      in   synchronous active-high reset
//   SurvValid  in   survivor word present; it is written this cycle
//   RamWe      out  RAM write strobe
//   RamAddr    out  RAM address {bank, step}
//   Init       out  one-cycle TBU init pulse at job start
//   TB_EN      out  TBU step enable and RAM read strobe
//   Hold       out  TBU decode (output-valid) phase
//   Busy       out  a job is active
//   Overrun    out  sticky: a job was preempted by a bank rotation
//   OvrCount   out  (TB_OVR_CNT_EN only) saturating preemption count
// ---------------------------------------------------------------------------
module tb_mem_sched #(
  parameter int WD_FSM = 6
) (
  input  logic              CLOCK,
  input  logic              Reset,
  input  logic              SurvValid,
  output logic              RamWe,
  output logic [WD_FSM+1:0] RamAddr,
  output logic              Init,
  output logic              TB_EN,
  output logic              Hold,
  output logic              Busy,
  output logic              Overrun
`ifdef TB_OVR_CNT_EN
  ,
  output logic [7:0]        OvrCount
`endif
);

  // The bank count is fixed; the address always carries two bank bits.
  localparam int N_BANK = 4;
  localparam int BANK_W = $clog2(N_BANK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_TB,
    S_DEC
  } state_t;

  state_t              r_state;
  logic [BANK_W-1:0]   r_wbank;
  logic [WD_FSM-1:0]   r_wstep;
  logic [1:0]          r_fill;
  logic [BANK_W-1:0]   r_cbank;
  logic [BANK_W-1:0]   r_rbank;
  logic [WD_FSM-1:0]   r_rstep;
  logic                r_overrun;
`ifdef TB_OVR_CNT_EN
  logic [7:0]          r_ovr_cnt;
`endif

  logic                w_rotate;
  logic [1:0]          w_fill_next;
  logic                w_launch;
  logic                w_grant;

  // A rotation happens when the last step of the current write bank is written.
  assign w_rotate    = SurvValid && (r_wstep == '1);
  assign w_fill_next = (r_fill == 2'd2) ? 2'd2 : (r_fill + 2'd1);
  // A job needs two complete banks: C for traceback and C-1 for decode.
  assign w_launch    = w_rotate && (w_fill_next == 2'd2);
  assign w_grant     = ((r_state == S_TB) || (r_state == S_DEC)) && !SurvValid;

  assign RamWe   = SurvValid;
  assign TB_EN   = w_grant;
  assign RamAddr = SurvValid ? {r_wbank, r_wstep} : {r_rbank, r_rstep};
  assign Init    = (r_state == S_INIT);
  assign Hold    = (r_state == S_DEC);
  assign Busy    = (r_state != S_IDLE);
  assign Overrun = r_overrun;
`ifdef TB_OVR_CNT_EN
  assign OvrCount = r_ovr_cnt;
`endif

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_wbank   <= '0;
      r_wstep   <= '0;
      r_fill    <= '0;
      r_cbank   <= '0;
      r_rbank   <= '0;
      r_rstep   <= '0;
      r_overrun <= 1'b0;
`ifdef TB_OVR_CNT_EN
      r_ovr_cnt <= '0;
`endif
    end else begin
      // Write side: step through the bank, then rotate to the next bank.
      if (SurvValid) begin
        r_wstep <= r_wstep + 1'b1;
        if (w_rotate) begin
          r_wbank <= r_wbank + 1'b1;
          r_fill  <= w_fill_next;
        end
      end

      // A launch overrides any job in flight. A rotation cycle always has
      // SurvValid=1, so no read is granted in that cycle and no read is lost.
      if (w_launch) begin
        r_cbank <= r_wbank;
        r_state <= S_INIT;
        if (r_state != S_IDLE) begin
          r_overrun <= 1'b1;
`ifdef TB_OVR_CNT_EN
          if (r_ovr_cnt != 8'hFF) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
          end
`endif
        end
      end else begin
        case (r_state)
          S_INIT: begin
            r_rbank <= r_cbank;
            r_rstep <= '1;
            r_state <= S_TB;
          end
          S_TB: begin
            if (w_grant) begin
              if (r_rstep == '0) begin
                r_rbank <= r_cbank - 1'b1;
                r_rstep <= '1;
                r_state <= S_DEC;
              end else begin
                r_rstep <= r_rstep - 1'b1;
              end
            end
          end
          S_DEC: begin
            if (w_grant) begin
              if (r_rstep == '0) begin
                r_state <= S_IDLE;
              end else begin
                r_rstep <= r_rstep - 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tb_mem_sched.sv
// ---------------------------------------------------------------------------
// tb_tb_mem_sched -- directed self-checking bench for tb_mem_sched
// (WD_FSM=6, so the RAM has 256 words in four banks of 64).
// A short table of post-reset vectors is followed by hand-written sequences:
// idle after reset, a normal job, a read/write collision, preemption,
// address wrap, and a reset during the decode phase.
// ---------------------------------------------------------------------------
module tb_tb_mem_sched;

  logic       clk;
  logic       Reset;
  logic       SurvValid;
  logic       RamWe;
  logic [7:0] RamAddr;
  logic       Init;
  logic       TB_EN;
  logic       Hold;
  logic       Busy;
  logic       Overrun;
`ifdef TB_OVR_CNT_EN
  logic [7:0] OvrCount;
`endif

  tb_mem_sched #(.WD_FSM(6)) dut (
    .CLOCK    (clk),
    .Reset    (Reset),
    .SurvValid(SurvValid),
    .RamWe    (RamWe),
    .RamAddr  (RamAddr),
    .Init     (Init),
    .TB_EN    (TB_EN),
    .Hold     (Hold),
    .Busy     (Busy),
    .Overrun  (Overrun)
`ifdef TB_OVR_CNT_EN
    ,
    .OvrCount (OvrCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  int cyc;
  int init_cnt;
  int init_cyc;
  int first_rd_cyc;
  int last_wr_cyc;
  logic [7:0] rd_q[$];
  logic       hold_q[$];
  logic [7:0] wr_q[$];
  logic [13:0] last_outs;
  logic        last_busy;
  logic        last_hold;
  logic        last_tben;
  logic        last_we;
  logic [7:0]  last_addr;

  typedef struct {
    logic        sv;
    logic [13:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1. It drives one cycle, samples outputs at the negedge,
  // and returns at the next posedge+1.
  task automatic tick(input logic sv);
    SurvValid = sv;
    @(negedge clk);
    last_outs = {RamWe, TB_EN, Init, Hold, Busy, Overrun, RamAddr};
    last_busy = Busy;
    last_hold = Hold;
    last_tben = TB_EN;
    last_we   = RamWe;
    last_addr = RamAddr;
    if (TB_EN) begin
      rd_q.push_back(RamAddr);
      hold_q.push_back(Hold);
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (RamWe) begin
      wr_q.push_back(RamAddr);
      last_wr_cyc = cyc;
    end
    if (Init) begin
      init_cnt++;
      if (init_cyc < 0) init_cyc = cyc;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rd_q.delete();
    hold_q.delete();
    wr_q.delete();
    init_cnt     = 0;
    init_cyc     = -1;
    first_rd_cyc = -1;
    last_wr_cyc  = -1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(1'b0);
    tick(1'b0);
    Reset = 1'b0;
    clear_log();
  endtask

  // Writes n survivor words, each followed by (gap) idle cycles.
  task automatic writes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick(1'b1);
      for (int g = 0; g < gap; g++) tick(1'b0);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    tick(1'b0);
    while (last_busy && n < 600) begin
      tick(1'b0);
      n++;
    end
    chk(name, {31'd0, last_busy}, 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    Reset = 1'b1;
    SurvValid = 1'b0;
    clear_log();
    @(posedge clk);
    #1;

    // ---- Table-driven vectors after reset ----
    vecs[0] = '{sv: 1'b1, exp: {1'b1, 5'b0, 8'd0}};
    vecs[1] = '{sv: 1'b0, exp: 14'd0};
    vecs[2] = '{sv: 1'b1, exp: {1'b1, 5'b0, 8'd1}};
    vecs[3] = '{sv: 1'b1, exp: {1'b1, 5'b0, 8'd2}};
    vecs[4] = '{sv: 1'b0, exp: 14'd0};
    vecs[5] = '{sv: 1'b1, exp: {1'b1, 5'b0, 8'd3}};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(vecs[i].sv);
      chk($sformatf("vec%0d", i), {18'd0, last_outs}, {18'd0, vecs[i].exp});
    end

    // ---- Reset and 50 idle cycles: every output stays 0 ----
    begin
      logic [13:0] acc;
      do_reset();
      acc = '0;
      for (int i = 0; i < 50; i++) begin
        tick(1'b0);
        acc = acc | last_outs;
      end
      chk("idle50_outputs", {18'd0, acc}, 32'd0);
    end

    // ---- Normal job: 128 writes at 1/3 duty ----
    do_reset();
    writes(64, 2);
    chk("no_job_after_bank0_init", init_cnt, 0);
    chk("no_job_after_bank0_busy", {31'd0, last_busy}, 32'd0);
    writes(64, 2);
    wait_idle("job1_timeout");
    chk("job1_wr_count", wr_q.size(), 128);
    for (int k = 0; k < wr_q.size() && k < 128; k++)
      chk($sformatf("job1_wr%0d", k), wr_q[k], k);
    chk("job1_init_count", init_cnt, 1);
    chk("job1_init_latency", init_cyc - last_wr_cyc, 1);
    chk("job1_first_read_latency", first_rd_cyc - init_cyc, 1);
    chk("job1_rd_count", rd_q.size(), 128);
    for (int k = 0; k < rd_q.size() && k < 128; k++) begin
      chk($sformatf("job1_rd%0d", k), rd_q[k], 127 - k);
      chk($sformatf("job1_hold%0d", k), hold_q[k], (k >= 64) ? 1 : 0);
    end
    chk("job1_overrun", {31'd0, Overrun}, 32'd0);

    // ---- Collision at read step 40 of bank 1 ----
    begin
      bit found;
      found = 1'b0;
      do_reset();
      writes(128, 2);
      for (int n = 0; n < 400 && !found; n++) begin
        if (Busy && !Hold && !Init && RamAddr == 8'd104) begin
          found = 1'b1;
          tick(1'b1);
          chk("coll_we", {31'd0, last_we}, 32'd1);
          chk("coll_tben", {31'd0, last_tben}, 32'd0);
          chk("coll_addr", {24'd0, last_addr}, 32'd128);
          tick(1'b0);
          chk("coll_reread_tben", {31'd0, last_tben}, 32'd1);
          chk("coll_reread_addr", {24'd0, last_addr}, 32'd104);
        end else begin
          tick(1'b0);
        end
      end
      chk("coll_reached_step40", {31'd0, found}, 32'd1);
      wait_idle("coll_timeout");
      chk("coll_rd_count", rd_q.size(), 128);
      for (int k = 0; k < rd_q.size() && k < 128; k++)
        chk($sformatf("coll_rd%0d", k), rd_q[k], 127 - k);
    end

    // ---- Continuous writes: preemption at write 192 ----
    do_reset();
    writes(192, 0);
    chk("pre_no_reads", rd_q.size(), 0);
    tick(1'b0);
    chk("pre_overrun", {31'd0, last_outs[8]}, 32'd1);
    chk("pre_init_count", init_cnt, 2);
`ifdef TB_OVR_CNT_EN
    chk("pre_ovr_count", {24'd0, OvrCount}, 32'd1);
`endif
    wait_idle("pre_timeout");
    chk("pre_rd_count", rd_q.size(), 128);
    for (int k = 0; k < rd_q.size() && k < 128; k++) begin
      chk($sformatf("pre_rd%0d", k), rd_q[k], 191 - k);
      chk($sformatf("pre_hold%0d", k), hold_q[k], (k >= 64) ? 1 : 0);
    end
    chk("pre_overrun_sticky", {31'd0, Overrun}, 32'd1);

    // ---- Wrap: 260 writes, one write per four cycles ----
    do_reset();
    writes(260, 3);
    wait_idle("wrap_timeout");
    chk("wrap_wr255", wr_q[255], 255);
    chk("wrap_wr256", wr_q[256], 0);
    chk("wrap_wr259", wr_q[259], 3);
    chk("wrap_rd_count", rd_q.size(), 384);
    for (int k = 0; k < 128 && rd_q.size() == 384; k++)
      chk($sformatf("wrap_rd%0d", k), rd_q[256 + k], 255 - k);
    chk("wrap_init_count", init_cnt, 3);
    chk("wrap_overrun", {31'd0, Overrun}, 32'd0);

    // ---- Reset during the decode phase ----
    begin
      int n;
      do_reset();
      writes(128, 2);
      n = 0;
      while (!last_hold && n < 400) begin
        tick(1'b0);
        n++;
      end
      chk("rst_reached_dec", {31'd0, last_hold}, 32'd1);
      tick(1'b0);
      Reset = 1'b1;
      tick(1'b0);
      Reset = 1'b0;
      tick(1'b0);
      chk("rst_outputs_zero", {18'd0, last_outs}, 32'd0);
      clear_log();
      writes(64, 2);
      tick(1'b0);
      tick(1'b0);
      chk("rst_no_job_64", init_cnt, 0);
      chk("rst_idle_64", {31'd0, last_busy}, 32'd0);
      writes(64, 2);
      chk("rst_job_128", init_cnt, 1);
      chk("rst_wr0", wr_q[0], 0);
      chk("rst_wr127", wr_q[127], 127);
      chk("rst_first_read", rd_q.size() > 0 ? rd_q[0] : 8'd0, 127);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
